issue_queue_wakeup: RTL and testbench

//  Unified issue queue feeding the EXE stage. Buffers renamed instructions from

---
 rtl/iq_pkg.sv | 30 +++
 rtl/iq_oldest_sel.sv | 42 ++++
 rtl/issue_queue_wakeup.sv | 130 +++++++++++++
 tb/tb_issue_queue_wakeup.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iq_pkg.sv
// Shared types for the unified issue queue: entry layout and the broadcast tag matcher.
package iq_pkg;

    localparam int TAG_W     = 6;
    localparam int PAYLOAD_W = 96;

    typedef struct packed {
        logic                 valid;
        logic                 rdyA;
        logic                 rdyB;
        logic [TAG_W-1:0]     srcA_tag;
        logic [TAG_W-1:0]     srcB_tag;
        logic [TAG_W-1:0]     dst_tag;
        logic                 regwr;
        logic [31:0]          instr_num;
        logic [PAYLOAD_W-1:0] payload;
    } iq_entry_t;

    // True when either broadcast port is valid and carries this tag.
    function automatic logic tag_hit(
        input logic [TAG_W-1:0] tag,
        input logic             flag0,
        input logic [TAG_W-1:0] map0,
        input logic             flag1,
        input logic [TAG_W-1:0] map1
    );
        return (flag0 && (tag == map0)) || (flag1 && (tag == map1));
    endfunction

endpackage

// File: rtl/iq_oldest_sel.sv
// Binary min-tree over the ready mask; picks the smallest instr_num, lower index on ties.
module iq_oldest_sel #(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] ready_mask,
    input  logic [31:0]      instr_num [DEPTH],
    output logic             sel_valid,
    output logic [IDX_W-1:0] sel_idx
);

    logic             node_v   [1:2*DEPTH-1];
    logic [IDX_W-1:0] node_idx [1:2*DEPTH-1];
    logic [31:0]      node_num [1:2*DEPTH-1];
    logic             take_r;

    // Leaves live at DEPTH..2*DEPTH-1; node n reduces children 2n and 2n+1.
    always_comb begin
        take_r = 1'b0;
        for (int n = 1; n < 2*DEPTH; n++) begin
            node_v[n]   = 1'b0;
            node_idx[n] = '0;
            node_num[n] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            node_v[DEPTH+i]   = ready_mask[i];
            node_idx[DEPTH+i] = IDX_W'(i);
            node_num[DEPTH+i] = instr_num[i];
        end
        for (int n = DEPTH-1; n >= 1; n--) begin
            take_r = node_v[2*n+1] &&
                     (!node_v[2*n] || (node_num[2*n+1] < node_num[2*n]));
            node_v[n]   = node_v[2*n] || node_v[2*n+1];
            node_idx[n] = take_r ? node_idx[2*n+1] : node_idx[2*n];
            node_num[n] = take_r ? node_num[2*n+1] : node_num[2*n];
        end
    end

    assign sel_valid = node_v[1];
    assign sel_idx   = node_idx[1];

endmodule

// File: rtl/issue_queue_wakeup.sv
// Unified issue queue: buffers dispatched instructions, wakes operands on EXE/LSQ
// broadcasts and issues the oldest ready entry through a registered bundle.
module issue_queue_wakeup
    import iq_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     disp_valid,
    output logic                     disp_ready,
    input  logic [TAG_W-1:0]         disp_srcA_tag,
    input  logic                     disp_srcA_rdy,
    input  logic [TAG_W-1:0]         disp_srcB_tag,
    input  logic                     disp_srcB_rdy,
    input  logic [TAG_W-1:0]         disp_dst_tag,
    input  logic                     disp_regwr,
    input  logic [31:0]              disp_instr_num,
    input  logic [PAYLOAD_W-1:0]     disp_payload,
    input  logic                     broadcast_flag,
    input  logic [TAG_W-1:0]         broadcast_Map,
    input  logic                     lsq_wb_flag,
    input  logic [TAG_W-1:0]         lsq_wb_map,
    input  logic                     flush,
    output logic                     issue_valid,
    output logic [TAG_W-1:0]         issue_srcA_tag,
    output logic [TAG_W-1:0]         issue_srcB_tag,
    output logic [TAG_W-1:0]         issue_RegWr_map,
    output logic                     issue_RegWr_flag,
    output logic [31:0]              issue_instr_num,
    output logic [PAYLOAD_W-1:0]     issue_payload,
    output logic [$clog2(DEPTH):0]   iq_count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    iq_entry_t        entries [DEPTH];
    logic [DEPTH-1:0] ready_mask;
    logic [31:0]      instr_nums [DEPTH];
    logic             sel_valid;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] free_idx;
    logic             accept;
    logic             do_issue;

    always_comb begin
        ready_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready_mask[i] = entries[i].valid && entries[i].rdyA && entries[i].rdyB;
            instr_nums[i] = entries[i].instr_num;
        end
    end

    iq_oldest_sel #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_sel (
        .ready_mask (ready_mask),
        .instr_num  (instr_nums),
        .sel_valid  (sel_valid),
        .sel_idx    (sel_idx)
    );

    // Scan from the top so the lowest free slot wins.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (!entries[i].valid) free_idx = IDX_W'(i);
        end
    end

    assign disp_ready = (iq_count < CNT_W'(DEPTH));
    assign accept     = disp_valid && disp_ready && !flush;
    assign do_issue   = sel_valid && !flush;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
            iq_count         <= '0;
            issue_valid      <= 1'b0;
            issue_srcA_tag   <= '0;
            issue_srcB_tag   <= '0;
            issue_RegWr_map  <= '0;
            issue_RegWr_flag <= 1'b0;
            issue_instr_num  <= '0;
            issue_payload    <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) entries[i].valid <= 1'b0;
            iq_count    <= '0;
            issue_valid <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entries[i].valid) begin
                    if (tag_hit(entries[i].srcA_tag, broadcast_flag, broadcast_Map,
                                lsq_wb_flag, lsq_wb_map))
                        entries[i].rdyA <= 1'b1;
                    if (tag_hit(entries[i].srcB_tag, broadcast_flag, broadcast_Map,
                                lsq_wb_flag, lsq_wb_map))
                        entries[i].rdyB <= 1'b1;
                end
            end
            issue_valid <= do_issue;
            if (do_issue) begin
                entries[sel_idx].valid <= 1'b0;
                issue_srcA_tag   <= entries[sel_idx].srcA_tag;
                issue_srcB_tag   <= entries[sel_idx].srcB_tag;
                issue_RegWr_map  <= entries[sel_idx].dst_tag;
                issue_RegWr_flag <= entries[sel_idx].regwr;
                issue_instr_num  <= entries[sel_idx].instr_num;
                issue_payload    <= entries[sel_idx].payload;
            end
            // The accepted slot is free and the issued one is valid, so they never collide.
            if (accept) begin
                entries[free_idx] <= '{
                    valid:     1'b1,
                    rdyA:      disp_srcA_rdy || tag_hit(disp_srcA_tag, broadcast_flag,
                                   broadcast_Map, lsq_wb_flag, lsq_wb_map),
                    rdyB:      disp_srcB_rdy || tag_hit(disp_srcB_tag, broadcast_flag,
                                   broadcast_Map, lsq_wb_flag, lsq_wb_map),
                    srcA_tag:  disp_srcA_tag,
                    srcB_tag:  disp_srcB_tag,
                    dst_tag:   disp_dst_tag,
                    regwr:     disp_regwr,
                    instr_num: disp_instr_num,
                    payload:   disp_payload
                };
            end
            iq_count <= iq_count + CNT_W'(accept) - CNT_W'(do_issue);
        end
    end

endmodule

// File: tb/tb_issue_queue_wakeup.sv
// Directed bench for issue_queue_wakeup with a queue-based reference model checked every cycle.
module tb_issue_queue_wakeup;
    import iq_pkg::*;

    localparam int DEPTH = 16;

    logic                 CLK = 1'b0;
    logic                 RESET = 1'b0;
    logic                 disp_valid = 1'b0;
    logic                 disp_ready;
    logic [TAG_W-1:0]     disp_srcA_tag = '0;
    logic                 disp_srcA_rdy = 1'b0;
    logic [TAG_W-1:0]     disp_srcB_tag = '0;
    logic                 disp_srcB_rdy = 1'b0;
    logic [TAG_W-1:0]     disp_dst_tag = '0;
    logic                 disp_regwr = 1'b0;
    logic [31:0]          disp_instr_num = '0;
    logic [PAYLOAD_W-1:0] disp_payload = '0;
    logic                 broadcast_flag = 1'b0;
    logic [TAG_W-1:0]     broadcast_Map = '0;
    logic                 lsq_wb_flag = 1'b0;
    logic [TAG_W-1:0]     lsq_wb_map = '0;
    logic                 flush = 1'b0;
    logic                 issue_valid;
    logic [TAG_W-1:0]     issue_srcA_tag;
    logic [TAG_W-1:0]     issue_srcB_tag;
    logic [TAG_W-1:0]     issue_RegWr_map;
    logic                 issue_RegWr_flag;
    logic [31:0]          issue_instr_num;
    logic [PAYLOAD_W-1:0] issue_payload;
    logic [4:0]           iq_count;

    int n_compared = 0;
    int n_mismatched = 0;

    issue_queue_wakeup #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET(RESET),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_srcA_tag(disp_srcA_tag), .disp_srcA_rdy(disp_srcA_rdy),
        .disp_srcB_tag(disp_srcB_tag), .disp_srcB_rdy(disp_srcB_rdy),
        .disp_dst_tag(disp_dst_tag), .disp_regwr(disp_regwr),
        .disp_instr_num(disp_instr_num), .disp_payload(disp_payload),
        .broadcast_flag(broadcast_flag), .broadcast_Map(broadcast_Map),
        .lsq_wb_flag(lsq_wb_flag), .lsq_wb_map(lsq_wb_map), .flush(flush),
        .issue_valid(issue_valid), .issue_srcA_tag(issue_srcA_tag),
        .issue_srcB_tag(issue_srcB_tag), .issue_RegWr_map(issue_RegWr_map),
        .issue_RegWr_flag(issue_RegWr_flag), .issue_instr_num(issue_instr_num),
        .issue_payload(issue_payload), .iq_count(iq_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic                 dv;
        logic [TAG_W-1:0]     a_tag;
        logic                 a_rdy;
        logic [TAG_W-1:0]     b_tag;
        logic                 b_rdy;
        logic [TAG_W-1:0]     dst;
        logic                 regwr;
        logic [31:0]          instr;
        logic                 bf;
        logic [TAG_W-1:0]     bm;
        logic                 lf;
        logic [TAG_W-1:0]     lm;
        logic                 fl;
    } stim_t;

    typedef struct {
        logic                 rdyA;
        logic                 rdyB;
        logic [TAG_W-1:0]     a_tag;
        logic [TAG_W-1:0]     b_tag;
        logic [TAG_W-1:0]     dst;
        logic                 regwr;
        logic [31:0]          instr;
        logic [PAYLOAD_W-1:0] payload;
    } model_ent_t;

    // Reference model: an unordered bag of waiting instructions plus the expected outputs.
    model_ent_t           q[$];
    logic                 m_issue_valid = 1'b0;
    logic [TAG_W-1:0]     m_srcA = '0;
    logic [TAG_W-1:0]     m_srcB = '0;
    logic [TAG_W-1:0]     m_map = '0;
    logic                 m_flag = 1'b0;
    logic [31:0]          m_instr = '0;
    logic [PAYLOAD_W-1:0] m_payload = '0;

    function automatic logic [PAYLOAD_W-1:0] pay(input logic [31:0] n);
        return {n, ~n, n ^ 32'h5a5a5a5a};
    endfunction

    function automatic logic bhit(input logic [TAG_W-1:0] t);
        return (broadcast_flag && broadcast_Map == t) || (lsq_wb_flag && lsq_wb_map == t);
    endfunction

    function automatic stim_t idle_s();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic stim_t disp_s(input logic [31:0] instr, input logic [TAG_W-1:0] a_tag,
                                     input logic a_rdy, input logic [TAG_W-1:0] b_tag,
                                     input logic b_rdy, input logic [TAG_W-1:0] dst);
        stim_t s;
        s = idle_s();
        s.dv = 1'b1; s.instr = instr; s.a_tag = a_tag; s.a_rdy = a_rdy;
        s.b_tag = b_tag; s.b_rdy = b_rdy; s.dst = dst; s.regwr = instr[0];
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle worth of inputs; returns at the negedge where they were applied.
    task automatic applyStimulus(input stim_t s);
        @(negedge CLK);
        disp_valid = s.dv;        disp_srcA_tag = s.a_tag;  disp_srcA_rdy = s.a_rdy;
        disp_srcB_tag = s.b_tag;  disp_srcB_rdy = s.b_rdy;  disp_dst_tag = s.dst;
        disp_regwr = s.regwr;     disp_instr_num = s.instr; disp_payload = pay(s.instr);
        broadcast_flag = s.bf;    broadcast_Map = s.bm;
        lsq_wb_flag = s.lf;       lsq_wb_map = s.lm;        flush = s.fl;
    endtask

    always @(negedge RESET) begin
        q.delete();
        m_issue_valid = 1'b0; m_srcA = '0; m_srcB = '0; m_map = '0;
        m_flag = 1'b0; m_instr = '0; m_payload = '0;
    end

    always @(posedge CLK) begin : model_step
        int         best;
        bit         acc;
        model_ent_t e;
        if (RESET) begin
            if (flush) begin
                q.delete();
                m_issue_valid = 1'b0;
            end else begin
                best = -1;
                foreach (q[i])
                    if (q[i].rdyA && q[i].rdyB && (best < 0 || q[i].instr < q[best].instr))
                        best = i;
                acc = disp_valid && (q.size() < DEPTH);
                foreach (q[i]) begin
                    if (bhit(q[i].a_tag)) q[i].rdyA = 1'b1;
                    if (bhit(q[i].b_tag)) q[i].rdyB = 1'b1;
                end
                m_issue_valid = (best >= 0);
                if (best >= 0) begin
                    m_srcA = q[best].a_tag;  m_srcB = q[best].b_tag;
                    m_map = q[best].dst;     m_flag = q[best].regwr;
                    m_instr = q[best].instr; m_payload = q[best].payload;
                    q.delete(best);
                end
                if (acc) begin
                    e.rdyA = disp_srcA_rdy || bhit(disp_srcA_tag);
                    e.rdyB = disp_srcB_rdy || bhit(disp_srcB_tag);
                    e.a_tag = disp_srcA_tag; e.b_tag = disp_srcB_tag;
                    e.dst = disp_dst_tag;    e.regwr = disp_regwr;
                    e.instr = disp_instr_num; e.payload = disp_payload;
                    q.push_back(e);
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (RESET) begin
            checkOutput("model_issue_valid", 128'(issue_valid), 128'(m_issue_valid));
            checkOutput("model_srcA", 128'(issue_srcA_tag), 128'(m_srcA));
            checkOutput("model_srcB", 128'(issue_srcB_tag), 128'(m_srcB));
            checkOutput("model_map", 128'(issue_RegWr_map), 128'(m_map));
            checkOutput("model_flag", 128'(issue_RegWr_flag), 128'(m_flag));
            checkOutput("model_instr", 128'(issue_instr_num), 128'(m_instr));
            checkOutput("model_payload", 128'(issue_payload), 128'(m_payload));
            checkOutput("model_count", 128'(iq_count), 128'(q.size()));
            checkOutput("model_disp_ready", 128'(disp_ready), 128'(q.size() < DEPTH));
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        stim_t s;
        repeat (3) @(negedge CLK);
        #2 RESET = 1'b1;

        // Reset state and single ready instruction.
        applyStimulus(disp_s(5, 1, 1'b1, 2, 1'b1, 12));
        checkOutput("reset_issue_valid", 128'(issue_valid), 128'd0);
        checkOutput("reset_count", 128'(iq_count), 128'd0);
        checkOutput("reset_disp_ready", 128'(disp_ready), 128'd1);
        applyStimulus(idle_s());
        checkOutput("t1_count_after_accept", 128'(iq_count), 128'd1);
        checkOutput("t1_no_issue_yet", 128'(issue_valid), 128'd0);
        applyStimulus(idle_s());
        checkOutput("t1_issue_valid", 128'(issue_valid), 128'd1);
        checkOutput("t1_map", 128'(issue_RegWr_map), 128'd12);
        checkOutput("t1_instr", 128'(issue_instr_num), 128'd5);
        checkOutput("t1_count_drained", 128'(iq_count), 128'd0);

        // Wakeup through the EXE broadcast.
        applyStimulus(disp_s(7, 20, 1'b0, 3, 1'b1, 13));
        applyStimulus(idle_s());
        applyStimulus(idle_s());
        checkOutput("t2_waiting", 128'(issue_valid), 128'd0);
        s = idle_s(); s.bf = 1'b1; s.bm = 20;
        applyStimulus(s);
        applyStimulus(idle_s());
        checkOutput("t2_not_before_wake", 128'(issue_valid), 128'd0);
        applyStimulus(idle_s());
        checkOutput("t2_issue_after_wake", 128'(issue_valid), 128'd1);
        checkOutput("t2_instr", 128'(issue_instr_num), 128'd7);

        // Oldest first when two become ready together.
        applyStimulus(disp_s(9, 30, 1'b0, 4, 1'b1, 14));
        applyStimulus(disp_s(3, 31, 1'b0, 5, 1'b1, 15));
        s = idle_s(); s.bf = 1'b1; s.bm = 30; s.lf = 1'b1; s.lm = 31;
        applyStimulus(s);
        applyStimulus(idle_s());
        applyStimulus(idle_s());
        checkOutput("t3_first_instr", 128'(issue_instr_num), 128'd3);
        applyStimulus(idle_s());
        checkOutput("t3_second_instr", 128'(issue_instr_num), 128'd9);
        checkOutput("t3_second_valid", 128'(issue_valid), 128'd1);
        applyStimulus(idle_s());
        checkOutput("t3_drained", 128'(issue_valid), 128'd0);

        // Fill to capacity; a full queue rejects even while it issues.
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(disp_s(100 + i, TAG_W'(16 + i), 1'b0, 6, 1'b1, TAG_W'(i)));
        s = idle_s(); s.bf = 1'b1; s.bm = 21;
        applyStimulus(s);
        checkOutput("t4_full_count", 128'(iq_count), 128'd16);
        checkOutput("t4_full_not_ready", 128'(disp_ready), 128'd0);
        applyStimulus(disp_s(200, 7, 1'b1, 8, 1'b1, 9));
        checkOutput("t4_still_full", 128'(iq_count), 128'd16);
        applyStimulus(idle_s());
        checkOutput("t4_issued_105", 128'(issue_instr_num), 128'd105);
        checkOutput("t4_count_15", 128'(iq_count), 128'd15);
        checkOutput("t4_ready_again", 128'(disp_ready), 128'd1);
        s = idle_s(); s.fl = 1'b1;
        applyStimulus(s);
        applyStimulus(idle_s());
        checkOutput("t4_flushed", 128'(iq_count), 128'd0);

        // Same-cycle LSQ bypass on dispatch.
        s = disp_s(40, 33, 1'b0, 10, 1'b1, 16); s.lf = 1'b1; s.lm = 33;
        applyStimulus(s);
        applyStimulus(idle_s());
        checkOutput("t5_count", 128'(iq_count), 128'd1);
        applyStimulus(idle_s());
        checkOutput("t5_issue_valid", 128'(issue_valid), 128'd1);
        checkOutput("t5_instr", 128'(issue_instr_num), 128'd40);

        // Flush beats a simultaneous dispatch.
        for (int i = 0; i < 8; i++)
            applyStimulus(disp_s(50 + i, TAG_W'(40 + i), 1'b0, 11, 1'b1, 17));
        s = disp_s(77, 1, 1'b1, 2, 1'b1, 18); s.fl = 1'b1;
        applyStimulus(s);
        checkOutput("t6_count_8", 128'(iq_count), 128'd8);
        applyStimulus(idle_s());
        checkOutput("t6_count_0", 128'(iq_count), 128'd0);
        checkOutput("t6_no_issue", 128'(issue_valid), 128'd0);
        applyStimulus(idle_s());
        checkOutput("t6_dropped", 128'(issue_valid), 128'd0);
        checkOutput("t6_still_empty", 128'(iq_count), 128'd0);

        // Asynchronous reset in the middle of operation.
        applyStimulus(disp_s(60, 50, 1'b0, 51, 1'b0, 19));
        applyStimulus(idle_s());
        @(negedge CLK);
        #2 RESET = 1'b0;
        #1;
        checkOutput("t7_async_count", 128'(iq_count), 128'd0);
        checkOutput("t7_async_map", 128'(issue_RegWr_map), 128'd0);
        checkOutput("t7_async_instr", 128'(issue_instr_num), 128'd0);
        @(negedge CLK);
        #2 RESET = 1'b1;
        applyStimulus(disp_s(61, 1, 1'b1, 2, 1'b1, 20));
        applyStimulus(idle_s());
        applyStimulus(idle_s());
        checkOutput("t7_issue_after_reset", 128'(issue_instr_num), 128'd61);
        applyStimulus(idle_s());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
